cond_status_unit: RTL and testbench
===================================

COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 freeze  input  1  pipeline stall; holds all state when high.
REQ-005 flush  input  1  pipeline flush; kills the ID-stage instruction.
REQ-006 statusBits  input  4  ALU flags {N,Z,C,V} from the current EXE-stage instruction.
REQ-007 exeS  input  1  EXE-stage instruction is valid and has its S bit set.
REQ-008 idValid  input  1  ID stage holds a valid instruction.
REQ-009 idCond  input  4  ARM condition field of the ID-stage instruction.
REQ-010 cntClr  input  1  synchronous clear of the annul counter.
REQ-011 srOut  output  4  status register {N,Z,C,V}.
REQ-012 carryOut  output  1  carry-in for the ALU, equal to srOut[1].
REQ-013 idExecute  output  1  combinational: the ID instruction is valid and its condition passes.
REQ-014 exeCondPass  output  1  registered idExecute, aligned to the EXE stage.
REQ-015 annulCount  output  16  saturating count of instructions annulled by their condition.

Function
REQ-016 SR update: on a rising edge with !freeze && exeS, SR SHALL load statusBits; otherwise SR holds its value.
REQ-017 Forwarding: the flags used for evaluation (effFlags) SHALL be statusBits when exeS=1, else SR; this lets back-to-back flag set/test work with zero bubbles.
REQ-018 Condition evaluation of idCond against effFlags {N,Z,C,V} SHALL be:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
REQ-019 idExecute SHALL equal idValid && pass && !flush, combinationally.
REQ-020 exeCondPass SHALL load idExecute on each rising edge with !freeze, and hold its value while freeze=1.
REQ-021 flush with !freeze SHALL load exeCondPass with 0.
REQ-022 flush with freeze SHALL hold exeCondPass; freeze has priority.
REQ-023 annulCount SHALL increment by 1 on an edge with !freeze && idValid && !pass && !flush.
REQ-024 annulCount SHALL saturate at 16'hFFFF with no wrap.
REQ-025 cntClr SHALL force annulCount to 0 on the next edge, regardless of freeze, taking priority over increment.
REQ-026 An SR write and an ID evaluation in the same cycle SHALL evaluate against forwarded statusBits, not the old SR.
REQ-027 The 1-cycle latency from idExecute to exeCondPass is fixed.
REQ-028 srOut and carryOut SHALL have zero latency from the SR register.

Reset
REQ-029 While rst=1, SR, exeCondPass and annulCount SHALL be 0 immediately, independent of clk.
REQ-030 While rst=1, srOut=4'b0000 and carryOut=0.
REQ-031 Reset asserted mid-operation (including during freeze or while the counter is saturated) SHALL clear all state within the same cycle.
REQ-032 The first edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-033 Reset, then exeS=1 with statusBits=4'b0100 and one edge -> srOut=4'b0100, carryOut=0.
REQ-034 SR=0100, exeS=1 with statusBits=0010, idValid=1 and idCond=0000 (EQ) -> idExecute=0 (forwarded Z=0); after one edge, exeCondPass=0, annulCount=1, srOut=0010.
REQ-035 Sweep all 16 idCond values against all 16 flag patterns with exeS=0 -> idExecute matches the REQ-018 table in all 256 cases.
REQ-036 freeze=1 with exeS=1, statusBits=1111 and flush=1 for 3 edges -> srOut, exeCondPass and annulCount are unchanged.
REQ-037 Preload annulCount to 16'hFFFE, then apply two annulled NV instructions -> FFFF, FFFF; then cntClr=1 together with an annulled instruction -> 0.
REQ-038 Assert rst asynchronously between edges with srOut=1010 and annulCount=5 -> all outputs are 0 before the next edge.

Source files
------------

// File: rtl/cond_status_unit_if.sv
// Bundles the pipeline-side signals of the condition/status unit.
// Carries the stall/flush controls, EXE flags, ID condition inputs and the status outputs.
// master drives the inputs and observes the outputs; slave is the unit itself.
interface cond_status_unit_if;
   logic        freeze;
   logic        flush;
   logic [3:0]  statusBits;
   logic        exeS;
   logic        idValid;
   logic [3:0]  idCond;
   logic        cntClr;
   logic [3:0]  srOut;
   logic        carryOut;
   logic        idExecute;
   logic        exeCondPass;
   logic [15:0] annulCount;

   modport master (
      output freeze, flush, statusBits, exeS, idValid, idCond, cntClr,
      input  srOut, carryOut, idExecute, exeCondPass, annulCount
   );

   modport slave (
      input  freeze, flush, statusBits, exeS, idValid, idCond, cntClr,
      output srOut, carryOut, idExecute, exeCondPass, annulCount
   );
endinterface

// File: rtl/cond_status_unit.sv
// ARM-style status register with flag forwarding, condition evaluation and an annul counter.
// idExecute is combinational; exeCondPass, SR and annulCount update one edge later.
// freeze holds all state (except a pending cntClr); no valid/ready backpressure.
module cond_status_unit (
   input  logic              clk,
   input  logic              rst,
   cond_status_unit_if.slave bus_if
);

   logic [3:0]  sr_q, sr_d;
   logic        exe_pass_q, exe_pass_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  eff_flags;
   logic        cond_pass;
   logic        flag_n, flag_z, flag_c, flag_v;

   // Forward the EXE flags so a set-then-test pair needs no bubble.
   assign eff_flags = bus_if.exeS ? bus_if.statusBits : sr_q;
   assign flag_n    = eff_flags[3];
   assign flag_z    = eff_flags[2];
   assign flag_c    = eff_flags[1];
   assign flag_v    = eff_flags[0];

   // Evaluate the ID-stage condition field against the effective flags.
   always_comb begin
      cond_pass = 1'b0;
      case (bus_if.idCond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign bus_if.idExecute = bus_if.idValid & cond_pass & ~bus_if.flush;

   // Next-state for SR, the EXE-aligned pass bit and the saturating annul counter.
   always_comb begin
      sr_d       = sr_q;
      exe_pass_d = exe_pass_q;
      cnt_d      = cnt_q;
      if (!bus_if.freeze) begin
         if (bus_if.exeS)
            sr_d = bus_if.statusBits;
         // idExecute already folds in flush, so a flush loads a zero here.
         exe_pass_d = bus_if.idExecute;
         if (bus_if.idValid && !cond_pass && !bus_if.flush && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
      end
      // Clear wins over both freeze and increment.
      if (bus_if.cntClr)
         cnt_d = 16'd0;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q       <= 4'b0000;
         exe_pass_q <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         sr_q       <= sr_d;
         exe_pass_q <= exe_pass_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus_if.srOut       = sr_q;
   assign bus_if.carryOut    = sr_q[1];
   assign bus_if.exeCondPass = exe_pass_q;
   assign bus_if.annulCount  = cnt_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed self-checking bench for cond_status_unit.
module tb_cond_status_unit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cond_status_unit_if bus ();

   cond_status_unit dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference condition: ARM pairs conditions, bit 0 inverts the base test.
   function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return cond[0] ? !base : base;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.freeze = 0; bus.flush = 0; bus.statusBits = 4'b0000; bus.exeS = 0;
      bus.idValid = 0; bus.idCond = 4'b1110; bus.cntClr = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #12;
      checks++; if (bus.srOut !== 4'b0000) begin errors++; $display("FAIL reset_sr got %b exp 0000", bus.srOut); end
      checks++; if (bus.carryOut !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", bus.carryOut); end
      checks++; if (bus.exeCondPass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", bus.exeCondPass); end
      checks++; if (bus.annulCount !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", bus.annulCount); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_sr_load();
      @(negedge clk);
      bus.exeS = 1; bus.statusBits = 4'b0100;
      tick();
      bus.exeS = 0;
      #1;
      checks++; if (bus.srOut !== 4'b0100) begin errors++; $display("FAIL sr_load got %b exp 0100", bus.srOut); end
      checks++; if (bus.carryOut !== 1'b0) begin errors++; $display("FAIL sr_load_carry got %b exp 0", bus.carryOut); end
   endtask

   task automatic test_forwarding();
      // SR=0100 (Z=1) but forwarded flags 0010 have Z=0, so EQ fails.
      bus.exeS = 1; bus.statusBits = 4'b0010; bus.idValid = 1; bus.idCond = 4'b0000;
      #1;
      checks++; if (bus.idExecute !== 1'b0) begin errors++; $display("FAIL fwd_idexec got %b exp 0", bus.idExecute); end
      tick();
      bus.exeS = 0; bus.idValid = 0;
      #1;
      checks++; if (bus.exeCondPass !== 1'b0) begin errors++; $display("FAIL fwd_pass got %b exp 0", bus.exeCondPass); end
      checks++; if (bus.annulCount !== 16'd1) begin errors++; $display("FAIL fwd_cnt got %h exp 0001", bus.annulCount); end
      checks++; if (bus.srOut !== 4'b0010) begin errors++; $display("FAIL fwd_sr got %b exp 0010", bus.srOut); end
      checks++; if (bus.carryOut !== 1'b1) begin errors++; $display("FAIL fwd_carry got %b exp 1", bus.carryOut); end
      // From SR (C=1): CS passes and lands in exeCondPass one edge later.
      bus.idValid = 1; bus.idCond = 4'b0010;
      #1;
      checks++; if (bus.idExecute !== 1'b1) begin errors++; $display("FAIL cs_idexec got %b exp 1", bus.idExecute); end
      tick();
      bus.idValid = 0;
      #1;
      checks++; if (bus.exeCondPass !== 1'b1) begin errors++; $display("FAIL cs_pass got %b exp 1", bus.exeCondPass); end
      checks++; if (bus.annulCount !== 16'd1) begin errors++; $display("FAIL cs_cnt got %h exp 0001", bus.annulCount); end
      tick();
      checks++; if (bus.exeCondPass !== 1'b0) begin errors++; $display("FAIL idle_pass got %b exp 0", bus.exeCondPass); end
   endtask

   task automatic test_cond_sweep();
      logic [3:0] f, c;
      logic       exp;
      for (int fi = 0; fi < 16; fi++) begin
         f = fi[3:0];
         bus.idValid = 0; bus.exeS = 1; bus.statusBits = f;
         tick();
         bus.exeS = 0; bus.statusBits = ~f; bus.idValid = 1;
         for (int ci = 0; ci < 16; ci++) begin
            c = ci[3:0];
            bus.idCond = c;
            #1;
            exp = cond_ref(c, f);
            checks++;
            if (bus.idExecute !== exp) begin
               errors++;
               $display("FAIL sweep cond=%b flags=%b got %b exp %b", c, f, bus.idExecute, exp);
            end
         end
      end
      bus.idValid = 0;
   endtask

   task automatic test_flush();
      // Clear the counter, then flush an AL and a failing instruction.
      bus.cntClr = 1;
      tick();
      bus.cntClr = 0;
      bus.idValid = 1; bus.idCond = 4'b1110; bus.flush = 1;
      #1;
      checks++; if (bus.idExecute !== 1'b0) begin errors++; $display("FAIL flush_idexec got %b exp 0", bus.idExecute); end
      tick();
      bus.idCond = 4'b1111;
      #1;
      checks++; if (bus.exeCondPass !== 1'b0) begin errors++; $display("FAIL flush_pass got %b exp 0", bus.exeCondPass); end
      tick();
      checks++; if (bus.annulCount !== 16'd0) begin errors++; $display("FAIL flush_cnt got %h exp 0000", bus.annulCount); end
      bus.flush = 0; bus.idValid = 0;
   endtask

   task automatic test_freeze();
      // Known state: SR=0101, exeCondPass=1, annulCount=2.
      bus.exeS = 1; bus.statusBits = 4'b0101; bus.idValid = 1; bus.idCond = 4'b1111;
      tick();
      bus.exeS = 0;
      tick();
      bus.idCond = 4'b1110;
      tick();
      bus.freeze = 1; bus.exeS = 1; bus.statusBits = 4'b1111; bus.flush = 1; bus.idCond = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.srOut !== 4'b0101) begin errors++; $display("FAIL freeze_sr%0d got %b exp 0101", i, bus.srOut); end
         checks++; if (bus.exeCondPass !== 1'b1) begin errors++; $display("FAIL freeze_pass%0d got %b exp 1", i, bus.exeCondPass); end
         checks++; if (bus.annulCount !== 16'd2) begin errors++; $display("FAIL freeze_cnt%0d got %h exp 0002", i, bus.annulCount); end
      end
      // cntClr acts even while frozen.
      bus.cntClr = 1;
      tick();
      bus.cntClr = 0;
      checks++; if (bus.annulCount !== 16'd0) begin errors++; $display("FAIL freeze_clr got %h exp 0000", bus.annulCount); end
      idle_inputs();
   endtask

   task automatic test_saturation();
      bus.idValid = 1; bus.idCond = 4'b1111;
      for (int i = 0; i < 16'hFFFE; i++) tick();
      checks++; if (bus.annulCount !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp FFFE", bus.annulCount); end
      tick();
      checks++; if (bus.annulCount !== 16'hFFFF) begin errors++; $display("FAIL sat_1 got %h exp FFFF", bus.annulCount); end
      tick();
      checks++; if (bus.annulCount !== 16'hFFFF) begin errors++; $display("FAIL sat_2 got %h exp FFFF", bus.annulCount); end
      bus.cntClr = 1;
      tick();
      bus.cntClr = 0;
      checks++; if (bus.annulCount !== 16'd0) begin errors++; $display("FAIL sat_clr got %h exp 0000", bus.annulCount); end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      bus.exeS = 1; bus.statusBits = 4'b1010; bus.idValid = 1; bus.idCond = 4'b1111;
      tick();
      bus.exeS = 0;
      for (int i = 0; i < 4; i++) tick();
      bus.idCond = 4'b1110;
      tick();
      bus.idValid = 0;
      checks++; if (bus.srOut !== 4'b1010 || bus.annulCount !== 16'd5 || bus.exeCondPass !== 1'b1) begin
         errors++; $display("FAIL arst_pre got sr=%b cnt=%h pass=%b exp 1010/0005/1", bus.srOut, bus.annulCount, bus.exeCondPass);
      end
      #2;
      rst = 1;
      #1;
      checks++; if (bus.srOut !== 4'b0000) begin errors++; $display("FAIL arst_sr got %b exp 0000", bus.srOut); end
      checks++; if (bus.carryOut !== 1'b0) begin errors++; $display("FAIL arst_carry got %b exp 0", bus.carryOut); end
      checks++; if (bus.exeCondPass !== 1'b0) begin errors++; $display("FAIL arst_pass got %b exp 0", bus.exeCondPass); end
      checks++; if (bus.annulCount !== 16'd0) begin errors++; $display("FAIL arst_cnt got %h exp 0000", bus.annulCount); end
      @(negedge clk);
      rst = 0;
      // First edge after release behaves normally.
      bus.exeS = 1; bus.statusBits = 4'b0011;
      tick();
      bus.exeS = 0;
      checks++; if (bus.srOut !== 4'b0011) begin errors++; $display("FAIL post_rst_sr got %b exp 0011", bus.srOut); end
      checks++; if (bus.carryOut !== 1'b1) begin errors++; $display("FAIL post_rst_carry got %b exp 1", bus.carryOut); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 0;
      test_reset();
      test_sr_load();
      test_forwarding();
      test_cond_sweep();
      test_flush();
      test_freeze();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
